demux_slot_sequencer: RTL and testbench

- Upstream stage for the 1:6 demultiplexer (D16).
- Accepts a serial bit stream over a valid/ready handshake and distributes the bits round-robin across the enabled output channels, one frame at a time.
- Drives the demux data input (din) and select (s) as a registered, mutually aligned pair.
- Signals the end of each frame so that downstream capture logic can latch the complete word.

---
 rtl/demux_slot_sequencer_pkg.sv | 50 +++++
 rtl/demux_slot_sequencer_if.sv | 40 ++++
 rtl/demux_slot_sequencer_priority_next_sel.sv | 34 +++
 rtl/demux_slot_sequencer.sv | 124 ++++++++++++
 tb/tb_demux_slot_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/demux_slot_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared types, defaults and the next-enabled-channel search used
//            by the demux slot sequencer.
// Contents : state_t            - sequencer FSM states (IDLE, RUN)
//            NCH_DEFAULT        - default channel count (6)
//            SEL_W_DEFAULT      - default select width (3)
//            next_sel_t         - search result {idx, last}
//            find_next_enabled  - lowest set mask bit at or above a bound
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int NCH_DEFAULT   = 6;
  localparam int SEL_W_DEFAULT = 3;
  // Widest supported channel count; the search runs on a zero-padded mask.
  localparam int MAX_CH        = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // last=1 means no enabled channel exists at or above the search bound,
  // i.e. the channel just below the bound was the final one of the frame.
  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } next_sel_t;

  function automatic next_sel_t find_next_enabled(
    input logic [MAX_CH-1:0] mask,
    input logic [3:0]        from_idx
  );
    next_sel_t res;
    res.idx  = 3'd0;
    res.last = 1'b1;
    // Walk downward so the lowest qualifying index is the one left standing.
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from_idx))) begin
        res.idx  = 3'(i);
        res.last = 1'b0;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot_sequencer_if
// Purpose  : Handshake and demux-drive bundle of the slot sequencer.
// Signals  : start, ch_en          - frame request and channel enable mask
//            in_valid, in_bit      - upstream serial bit (valid side)
//            in_ready              - sequencer accepts in_bit (ready side)
//            busy                  - frame in progress
//            sel, dout, dout_valid - registered demux select / data / strobe
//            frame_done            - strobe with the last bit of a frame
// Modports : master - frame/bit source and output observer
//            slave  - the sequencer itself
// Revision : 1.0 - initial release
// ============================================================================
interface demux_slot_sequencer_if #(
  parameter int NCH  = 6,
  parameter int SELW = 3
);
  logic            start;
  logic [NCH-1:0]  ch_en;
  logic            in_valid;
  logic            in_bit;
  logic            in_ready;
  logic            busy;
  logic [SELW-1:0] sel;
  logic            dout;
  logic            dout_valid;
  logic            frame_done;

  modport master (
    output start, ch_en, in_valid, in_bit,
    input  in_ready, busy, sel, dout, dout_valid, frame_done
  );

  modport slave (
    input  start, ch_en, in_valid, in_bit,
    output in_ready, busy, sel, dout, dout_valid, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/demux_slot_sequencer_priority_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : priority_next_sel
// Purpose  : Combinational finder of the lowest enabled channel at or above
//            a bound. Bound 0 gives the first channel of a new frame; bound
//            ptr+1 gives the channel following ptr.
// Ports    : mask     in  NCH    channel enable mask
//            from_idx in  SELW+1 lowest index considered (may equal NCH)
//            idx      out SELW   found channel index (0 when none)
//            last     out 1      no enabled channel at or above from_idx
// Revision : 1.0 - initial release
// ============================================================================
module priority_next_sel
  import demux_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int SELW = SEL_W_DEFAULT
) (
  input  wire  [NCH-1:0]  mask,
  input  wire  [SELW:0]   from_idx,
  output logic [SELW-1:0] idx,
  output logic            last
);

  next_sel_t w_res;

  always_comb begin
    w_res = find_next_enabled(MAX_CH'(mask), 4'(from_idx));
    idx   = SELW'(w_res.idx);
    last  = w_res.last;
  end

endmodule
`default_nettype wire

// File: rtl/demux_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot_sequencer
// Purpose  : Distributes a serial bit stream round-robin over the enabled
//            outputs of a 1:NCH demultiplexer, one frame per start request,
//            driving the demux select and data as a registered aligned pair.
// Ports    : clk  in  1  system clock (rising edge)
//            rst  in  1  asynchronous active-high reset
//            bus  slave modport of demux_slot_sequencer_if:
//                   start, ch_en, in_valid, in_bit        (in)
//                   in_ready, busy, sel, dout,
//                   dout_valid, frame_done                (out)
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot_sequencer
  import demux_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int SELW = SEL_W_DEFAULT
) (
  input wire clk,
  input wire rst,
  demux_slot_sequencer_if.slave bus
);

  state_t          r_state;
  state_t          w_state_next;
  logic [NCH-1:0]  r_mask;
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] r_sel;
  logic            r_dout;
  logic            r_dout_valid;
  logic            r_frame_done;
  logic            r_busy;

  logic            w_run;
  logic            w_accept;
  logic            w_start_ok;
  logic [NCH-1:0]  w_srch_mask;
  logic [SELW:0]   w_srch_from;
  logic [SELW-1:0] w_srch_idx;
  logic            w_srch_last;

  assign w_run      = (r_state == ST_RUN);
  assign w_accept   = w_run & bus.in_valid;
  assign w_start_ok = ~w_run & bus.start & (|bus.ch_en);

  // One finder serves both phases: in IDLE it looks for the first channel of
  // the incoming mask, in RUN for the channel after ptr in the latched mask.
  assign w_srch_mask = w_run ? r_mask : bus.ch_en;
  assign w_srch_from = w_run ? ({1'b0, r_ptr} + (SELW+1)'(1)) : '0;

  priority_next_sel #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_next_sel (
    .mask     (w_srch_mask),
    .from_idx (w_srch_from),
    .idx      (w_srch_idx),
    .last     (w_srch_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_next = ST_RUN;
      // In RUN, "last" means nothing enabled above ptr: this accept ends it.
      ST_RUN:  if (w_accept && w_srch_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask       <= '0;
      r_ptr        <= '0;
      r_sel        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_RUN);

      if (w_start_ok) begin
        r_mask <= bus.ch_en;
        r_ptr  <= w_srch_idx;
      end

      if (w_accept) begin
        r_sel        <= r_ptr;
        r_dout       <= bus.in_bit;
        r_dout_valid <= 1'b1;
        r_frame_done <= w_srch_last;
        if (!w_srch_last) begin
          r_ptr <= w_srch_idx;
        end
      end else begin
        // Data forced low keeps every demux output low between bits;
        // sel is left alone so the select lines do not toggle needlessly.
        r_dout       <= 1'b0;
        r_dout_valid <= 1'b0;
        r_frame_done <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_run;
  assign bus.busy       = r_busy;
  assign bus.sel        = r_sel;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_demux_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_slot_sequencer
// Purpose  : Self-checking bench for demux_slot_sequencer. A frame is modelled
//            as a queue of enabled channel indices; each accepted bit pops the
//            queue and the popped index is the expected select.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_slot_sequencer;
  import demux_pkg::*;

  localparam int NCH  = 6;
  localparam int SELW = 3;

  logic clk;
  logic rst;

  demux_slot_sequencer_if #(.NCH(NCH), .SELW(SELW)) bus ();

  demux_slot_sequencer #(.NCH(NCH), .SELW(SELW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  bit         m_run;
  int         m_q[$];
  logic [2:0] m_sel;
  logic       m_dout;
  logic       m_dv;
  logic       m_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_q    = {};
    m_sel  = 3'd0;
    m_dout = 1'b0;
    m_dv   = 1'b0;
    m_fd   = 1'b0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".busy"},       32'(bus.busy),       32'(m_run));
    chk({ctx, ".in_ready"},   32'(bus.in_ready),   32'(m_run));
    chk({ctx, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_dv));
    chk({ctx, ".dout"},       32'(bus.dout),       32'(m_dout));
    chk({ctx, ".sel"},        32'(bus.sel),        32'(m_sel));
    chk({ctx, ".frame_done"}, 32'(bus.frame_done), 32'(m_fd));
  endtask

  // Called at posedge+1: drive inputs, predict the next edge, check after it.
  task automatic step(input logic s, input logic [NCH-1:0] en, input logic v, input logic b);
    bus.start    = s;
    bus.ch_en    = en;
    bus.in_valid = v;
    bus.in_bit   = b;
    if (!m_run) begin
      m_dv = 0; m_dout = 0; m_fd = 0;
      if (s && en != 0) begin
        m_q = {};
        for (int i = 0; i < NCH; i++) if (en[i]) m_q.push_back(i);
        m_run = 1;
      end
    end else if (v) begin
      m_sel  = 3'(m_q.pop_front());
      m_dout = b;
      m_dv   = 1;
      m_fd   = (m_q.size() == 0);
      if (m_fd) m_run = 0;
    end else begin
      m_dv = 0; m_dout = 0; m_fd = 0;
    end
    @(posedge clk);
    #1;
    check_outputs("step");
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] bits;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.ch_en    = '0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
    step(0, '0, 0, 0);

    // Reset mid-frame
    step(1, 6'b111111, 0, 0);
    step(0, 6'b111111, 1, 1);
    step(0, 6'b111111, 1, 0);
    step(0, 6'b111111, 1, 1);
    apply_reset();
    step(0, 6'b111111, 1, 1);

    // Full frame 1,0,1,1,0,1
    bits = 6'b101101;
    step(1, 6'b111111, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 6'b111111, 1, bits[i]);
    step(0, 6'b111111, 1, 1);

    // Sparse mask, ch_en changed mid-frame
    step(1, 6'b100101, 0, 0);
    step(0, 6'b100101, 1, 1);
    step(0, 6'b000001, 1, 1);
    step(0, 6'b000001, 1, 1);
    step(0, 6'b000001, 0, 0);

    // Single channel
    step(1, 6'b010000, 0, 0);
    step(0, 6'b010000, 1, 1);
    step(0, 6'b010000, 0, 0);

    // Backpressure, start during RUN, start with empty mask
    step(1, 6'b111111, 0, 0);
    step(0, 6'b111111, 1, 1);
    step(1, 6'b000011, 0, 1);
    step(0, 6'b111111, 0, 1);
    step(0, 6'b111111, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 6'b111111, 1, 1);
    step(1, 6'b000000, 1, 1);
    step(0, 6'b000000, 0, 0);

    // Back-to-back frames
    step(1, 6'b001010, 0, 0);
    step(0, 6'b001010, 1, 1);
    step(0, 6'b001010, 1, 0);
    step(1, 6'b110100, 1, 1);
    step(0, 6'b110100, 1, 1);
    step(0, 6'b110100, 1, 0);
    step(0, 6'b110100, 1, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        logic [5:0] en;
        en = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        step(($urandom_range(0, 3) == 0), en, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
